// File: rtl/data_memory_lsu.sv
// Request/response data memory with B/H/W/D byte-lane stores, extended loads and programmable latency.
// Define DATAMEM_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of forcing alignment.
module data_memory_lsu #(
    parameter int unsigned ADDR_WIDTH   = 64,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned DEPTH_2POW   = 12,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic                  req_write_in,
    input  logic [1:0]            req_size_in,
    input  logic                  req_unsigned_in,
    input  logic [ADDR_WIDTH-1:0] address_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  resp_valid_out,
    input  logic                  resp_ready_in,
    output logic [DATA_WIDTH-1:0] resp_data_out,
    output logic                  resp_error_out
);

    localparam int unsigned WORD_BYTES = DATA_WIDTH / 8;
    localparam int unsigned WB2        = $clog2(WORD_BYTES);
    localparam int unsigned ALO        = DEPTH_2POW + WB2;
    localparam int unsigned WAIT_LAST  = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [1:0]            wait_cnt;
    logic [DATA_WIDTH-1:0] mem [2**DEPTH_2POW];

    logic [3:0]            nbytes;
    logic [WB2-1:0]        offset;
    logic [WB2-1:0]        size_mask;
    logic [WB2-1:0]        off_al;
    logic [DEPTH_2POW-1:0] word_idx;
    logic [ALO:0]          span_end;
    logic                  range_err;
    logic                  size_err;
    logic                  access_err;
    logic                  accept;
    logic                  sign_bit;
    logic [DATA_WIDTH-1:0] val_mask;
    logic [DATA_WIDTH-1:0] wr_mask;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] ld_ext;

    always_comb begin
        nbytes    = 4'd1 << req_size_in;
        size_mask = WB2'(nbytes - 4'd1);
        offset    = address_in[WB2-1:0];
        word_idx  = address_in[ALO-1:WB2];
        // Range test uses the raw address so a forced-alignment build still flags accesses past the end.
        span_end  = {1'b0, address_in[ALO-1:0]} + (ALO+1)'(nbytes - 4'd1);
        range_err = (|address_in[ADDR_WIDTH-1:ALO]) || span_end[ALO];
        size_err  = (WORD_BYTES < 8) && (req_size_in == 2'b11);
`ifdef DATAMEM_MISALIGN_TRAP_EN
        access_err = range_err || size_err || (|(offset & size_mask));
        off_al     = offset;
`else
        access_err = range_err || size_err;
        off_al     = offset & ~size_mask;
`endif
        accept = req_valid_in && req_ready_out && !rst_in;

        case (req_size_in)
            2'b00:   val_mask = DATA_WIDTH'(64'h0000_0000_0000_00FF);
            2'b01:   val_mask = DATA_WIDTH'(64'h0000_0000_0000_FFFF);
            2'b10:   val_mask = DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
            default: val_mask = '1;
        endcase

        rd_word  = mem[word_idx];
        rd_shift = rd_word >> {off_al, 3'b000};
        case (req_size_in)
            2'b00:   sign_bit = rd_shift[7];
            2'b01:   sign_bit = rd_shift[15];
            2'b10:   sign_bit = rd_shift[31];
            default: sign_bit = rd_shift[DATA_WIDTH-1];
        endcase
        ld_ext = (rd_shift & val_mask) | ((sign_bit && !req_unsigned_in) ? ~val_mask : '0);

        wr_mask = val_mask << {off_al, 3'b000};
        wr_word = data_in << {off_al, 3'b000};
    end

    // Storage is never reset; a store commits on its acceptance edge.
    always_ff @(posedge clk_in) begin
        if (accept && req_write_in && !access_err) begin
            mem[word_idx] <= (rd_word & ~wr_mask) | (wr_word & wr_mask);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            req_ready_out  <= 1'b1;
            resp_valid_out <= 1'b0;
            resp_data_out  <= '0;
            resp_error_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        resp_error_out <= access_err;
                        resp_data_out  <= (access_err || req_write_in) ? '0 : ld_ext;
                        req_ready_out  <= 1'b0;
                        wait_cnt       <= '0;
                        if (READ_LATENCY == 1) begin
                            state          <= RESP;
                            resp_valid_out <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'(WAIT_LAST)) begin
                        state          <= RESP;
                        resp_valid_out <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                RESP: begin
                    if (resp_ready_in) begin
                        state          <= IDLE;
                        resp_valid_out <= 1'b0;
                        req_ready_out  <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    resp_valid_out <= 1'b0;
                    req_ready_out  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: four instances (READ_LATENCY 1..4) driven in lockstep against a byte-array scoreboard.
module tb_data_memory_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] address;
    logic [63:0] wdata;
    logic        resp_ready;
    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_error;
    logic [63:0] resp_data [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        data_memory_lsu #(
            .ADDR_WIDTH  (64),
            .DATA_WIDTH  (64),
            .DEPTH_2POW  (12),
            .READ_LATENCY(g + 1)
        ) u_dut (
            .clk_in         (clk),
            .rst_in         (rst),
            .req_valid_in   (req_valid),
            .req_ready_out  (req_ready[g]),
            .req_write_in   (req_write),
            .req_size_in    (req_size),
            .req_unsigned_in(req_unsigned),
            .address_in     (address),
            .data_in        (wdata),
            .resp_valid_out (resp_valid[g]),
            .resp_ready_in  (resp_ready),
            .resp_data_out  (resp_data[g]),
            .resp_error_out (resp_error[g])
        );
    end

    typedef struct packed {
        logic        err;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  model [32768];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] got;
    logic        got_err;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Reference behaviour: capacity 0x8000 bytes, little-endian byte array.
    function automatic exp_t model_access(input bit wr, input logic [1:0] sz, input bit uns,
                                          input logic [63:0] addr, input logic [63:0] d);
        exp_t        e;
        int unsigned n;
        logic [63:0] a;
        logic [63:0] v;
        logic [14:0] idx;
        n = 32'd1 << sz;
        a = addr;
        v = '0;
        e.err = (addr > 64'h7FFF) || (addr + 64'(n) - 64'd1 > 64'h7FFF);
        if ((addr % 64'(n)) != 64'd0) begin
`ifdef DATAMEM_MISALIGN_TRAP_EN
            e.err = 1'b1;
`else
            a = addr - (addr % 64'(n));
`endif
        end
        if (!e.err) begin
            for (int unsigned i = 0; i < n; i++) begin
                idx = a[14:0] + 15'(i);
                if (wr) model[idx] = 8'(d >> (8 * i));
                else    v = v | (64'(model[idx]) << (8 * i));
            end
            if (!uns && n < 8 && ((v >> (8 * n - 1)) & 64'd1) != 64'd0)
                v = v | (~64'd0 << (8 * n));
        end
        e.data = (wr || e.err) ? 64'd0 : v;
        return e;
    endfunction

    task automatic xact(input bit wr, input logic [1:0] sz, input bit uns, input logic [63:0] addr,
                        input logic [63:0] d, input int hold, input bit rst_end,
                        output logic [63:0] res, output logic res_err);
        exp_t e;
        @(negedge clk);
        for (int g = 0; g < 4; g++) check($sformatf("ready_idle%0d", g), 64'(req_ready[g]), 64'd1);
        exp_q.push_back(model_access(wr, sz, uns, addr, d));
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        address      = addr;
        wdata        = d;
        resp_ready   = 1'b0;
        @(posedge clk);
        #1;
        // Request-side junk while busy must be ignored.
        req_write = 1'b1;
        req_size  = 2'($urandom_range(0, 3));
        address   = 64'($urandom_range(0, 255));
        wdata     = {$urandom, $urandom};
        e = exp_q.pop_front();
        for (int k = 0; k <= 3 + hold; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            for (int g = 0; g < 4; g++) begin
                check($sformatf("valid%0d_k%0d", g, k), 64'(resp_valid[g]), 64'(k >= g));
                check($sformatf("busy%0d_k%0d", g, k), 64'(req_ready[g]), 64'd0);
                if (k >= g) begin
                    check($sformatf("data%0d_a%0h", g, addr), resp_data[g], e.data);
                    check($sformatf("err%0d_a%0h", g, addr), 64'(resp_error[g]), 64'(e.err));
                end
            end
        end
        res     = resp_data[0];
        res_err = resp_error[0];
        if (rst_end) rst = 1'b1;
        else         resp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        rst        = 1'b0;
        for (int g = 0; g < 4; g++) begin
            check($sformatf("done_valid%0d", g), 64'(resp_valid[g]), 64'd0);
            check($sformatf("done_ready%0d", g), 64'(req_ready[g]), 64'd1);
        end
    endtask

    // Store accepted, then reset while the response is still pending.
    task automatic store_then_reset(input logic [1:0] sz, input logic [63:0] addr, input logic [63:0] d);
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = sz;
        address   = addr;
        wdata     = d;
        @(posedge clk);
        #1;
        e = model_access(1'b1, sz, 1'b0, addr, d);
        req_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int g = 0; g < 4; g++) begin
            check($sformatf("rst_wait_valid%0d", g), 64'(resp_valid[g]), 64'd0);
            check($sformatf("rst_wait_ready%0d", g), 64'(req_ready[g]), 64'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        address      = '0;
        wdata        = '0;
        resp_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            check($sformatf("rst_ready%0d", g), 64'(req_ready[g]), 64'd1);
            check($sformatf("rst_valid%0d", g), 64'(resp_valid[g]), 64'd0);
            check($sformatf("rst_data%0d", g), resp_data[g], 64'd0);
            check($sformatf("rst_err%0d", g), 64'(resp_error[g]), 64'd0);
        end
        rst = 1'b0;

        for (int a = 0; a < 256; a += 8)
            xact(1'b1, 2'd3, 1'b0, 64'(a), {$urandom, $urandom}, 0, 1'b0, got, got_err);

        xact(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, 0, 1'b0, got, got_err);
        xact(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0, 1'b0, got, got_err);
        check("t1_load_d", got, 64'h1122334455667788);
        check("t1_load_err", 64'(got_err), 64'd0);

        xact(1'b1, 2'd0, 1'b0, 64'h13, 64'hAA, 0, 1'b0, got, got_err);
        xact(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 0, 1'b0, got, got_err);
        check("t2_lane", got, 64'h11223344AA667788);
        xact(1'b0, 2'd0, 1'b0, 64'h13, 64'd0, 0, 1'b0, got, got_err);
        check("t2_lb_signed", got, 64'hFFFFFFFFFFFFFFAA);
        xact(1'b0, 2'd0, 1'b1, 64'h13, 64'd0, 0, 1'b0, got, got_err);
        check("t2_lb_unsigned", got, 64'h00000000000000AA);

        xact(1'b1, 2'd3, 1'b0, 64'h7FF8, 64'hCAFEF00DDEADBEEF, 0, 1'b0, got, got_err);
        xact(1'b1, 2'd2, 1'b0, 64'h7FFE, 64'h0102030405060708, 0, 1'b0, got, got_err);
        check("t3_oor_err", 64'(got_err), 64'd1);
        check("t3_oor_data", got, 64'd0);
        xact(1'b0, 2'd3, 1'b0, 64'h7FF8, 64'd0, 0, 1'b0, got, got_err);
        check("t3_last_word", got, 64'hCAFEF00DDEADBEEF);
        xact(1'b0, 2'd0, 1'b1, 64'h7FFF, 64'd0, 0, 1'b0, got, got_err);
        check("t3_last_byte", got, 64'hCA);
        xact(1'b0, 2'd1, 1'b0, 64'h7FFF, 64'd0, 0, 1'b0, got, got_err);
        check("t3_edge_half_err", 64'(got_err), 64'd1);
        xact(1'b0, 2'd3, 1'b0, 64'h8000_0000_0000_0010, 64'd0, 0, 1'b0, got, got_err);
        check("t3_high_bit_err", 64'(got_err), 64'd1);

        xact(1'b1, 2'd3, 1'b0, 64'h20, 64'h0123456789ABCDEF, 0, 1'b0, got, got_err);
        xact(1'b0, 2'd1, 1'b1, 64'h21, 64'd0, 0, 1'b0, got, got_err);
`ifdef DATAMEM_MISALIGN_TRAP_EN
        check("t4_misalign_err", 64'(got_err), 64'd1);
        check("t4_misalign_data", got, 64'd0);
`else
        check("t4_misalign_err", 64'(got_err), 64'd0);
        check("t4_misalign_data", got, 64'hCDEF);
`endif

        xact(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 5, 1'b1, got, got_err);
        check("t5_held_data", got, 64'h11223344AA667788);
        store_then_reset(2'd0, 64'h30, 64'h5A);
        xact(1'b0, 2'd0, 1'b1, 64'h30, 64'd0, 0, 1'b0, got, got_err);
        check("t5_committed", got, 64'h5A);

        for (int i = 0; i < 60; i++)
            xact(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 64'($urandom_range(0, 255)), {$urandom, $urandom}, $urandom_range(0, 2), 1'b0,
                 got, got_err);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
